countdown_timer_ctrl: RTL and testbench
=======================================

# countdown_timer_ctrl

Parametrised mm:ss countdown-timer controller. It replaces a bare state machine that only emits enables: this block also owns the BCD time registers, the one-second prescaler, the LED flash generator and the preset reload. It adds pause/resume, an auto-repeat mode and a synchronous clear. It sits between the debounced key/switch inputs and the HEX/LEDR display drivers.

## Interface
- `TICK_DIV`, 50000000: clocks per one-second decrement tick (≥2).
- `FLASH_DIV`, 25000000: clocks per LED toggle in FLASH (≥2).
- `LED_W`, 10: width of the LED bank.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `clr` in 1: synchronous clear, one-cycle pulse.
- `set` in 1: one-cycle pulse, debounced upstream.
- `startStop` in 1: one-cycle pulse, debounced upstream.
- `repeat_en` in 1: level; 1 reloads the preset and keeps running on expiry.
- `sw` in 8: BCD digit pair, {tens, ones}.
- `min_bcd` out 8: minutes, {tens, ones}.
- `sec_bcd` out 8: seconds, {tens, ones}.
- `ledr` out LED_W: flash output.
- `state_o` out 3: current state code.
- `running` out 1: high in RUN.
- `done` out 1: one-cycle pulse on each expiry.

## Operation
- States and codes: IDLE=0, SET_SEC=1, SET_MIN=2, READY=3, RUN=4, FLASH=5. Codes 6 and 7 go to IDLE on the next edge.
- Switch validation, applied whenever sw is captured:
  - any ones nibble >9 becomes 9;
  - seconds tens >5 becomes 5;
  - minutes tens >9 becomes 9.
- Input priority every cycle: clr, then expiry, then startStop, then set. Lower-priority pulses in the same cycle are dropped.
- clr in any state: go to IDLE; clear time, preset, prescaler, ledr and flash counter.
- IDLE: go unconditionally to SET_SEC on the next edge.
- SET_SEC: sec_bcd follows validated sw every cycle. set → SET_MIN.
- SET_MIN: min_bcd follows validated sw every cycle. set → READY; preset ← {min_bcd, sec_bcd}; prescaler ← 0.
- READY:
  - startStop with time ≠ 00:00 → RUN;
  - startStop with time = 00:00 is ignored;
  - set → SET_SEC; the time registers are then overwritten live from sw.
- RUN:
  - the prescaler counts 0..TICK_DIV-1; at the TICK_DIV-1 wrap the time decrements by one second;
  - BCD decrement: seconds x0 → (x-1)9; seconds 00 → 59 with a minutes borrow, using the same BCD rule;
  - startStop → READY (pause); the prescaler value is held, not cleared, so resume keeps the fractional second;
  - set is ignored.
- Expiry: a decrement that yields 00:00. done pulses once per expiry.
  - repeat_en=1: time ← preset, prescaler ← 0, stay in RUN.
  - repeat_en=0: go to FLASH.
- FLASH:
  - ledr is all-ones on entry and inverts every FLASH_DIV clocks;
  - startStop → READY with time ← preset, prescaler ← 0, ledr ← 0;
  - set is ignored.
- ledr is 0 in every state except FLASH.

## Timing
- reset low, asynchronously and immediately:
  - state = IDLE;
  - min_bcd, sec_bcd, preset, prescaler, flash counter = 0;
  - ledr = 0, running = 0, done = 0.
- After reset deasserts: IDLE lasts exactly one cycle, then SET_SEC.
- All outputs are registered. Transitions and state_o update on the edge that samples the pulse, so there is 1 cycle of latency.
- SET_SEC/SET_MIN live-follow: the output shows validated sw one cycle after sw changes.
- First decrement comes TICK_DIV cycles after entering RUN from a cleared prescaler.
- done: high in the cycle after the expiring tick edge. That is the same cycle state_o shows FLASH, or the reloaded time in repeat mode.
- Tick edge and startStop in the same cycle:
  - the decrement is committed and the state goes to READY;
  - if that decrement expires, expiry wins and startStop is dropped.
- clr together with any other input: clr wins.
- Asynchronous reset mid-RUN or mid-FLASH: all registers clear immediately, with no done pulse.
- Minimum timer value: 00:01 expires after exactly TICK_DIV cycles in RUN.

## Test plan
Parameters for all scenarios: TICK_DIV=4, FLASH_DIV=3.
- Reset and validation:
  - release reset; sw=8'h7C then set; sw=8'hA3 then set;
  - required: IDLE for 1 cycle, then SET_SEC; sec_bcd=8'h59; min_bcd=8'h93; state READY.
- Borrow chain:
  - preset 01:00; startStop;
  - required: after 4 cycles time = 00:59; after 240 cycles total, done pulses once and state = FLASH.
- Pause and resume:
  - preset 00:05; run 6 cycles; startStop; wait 20 cycles; startStop;
  - required: time frozen at 00:04 during the wait; next decrement 2 cycles after resume.
- Repeat mode:
  - preset 00:02, repeat_en=1; run 24 cycles;
  - required: done pulses at cycles 8, 16 and 24; time reloads to 00:02; running stays 1.
- Flash and restart:
  - expire with repeat_en=0;
  - required: ledr = all-ones for 3 cycles, then 0 for 3 cycles, repeating; startStop → READY, time = preset, ledr = 0.
- Priority:
  - clr together with startStop in RUN → IDLE;
  - tick and startStop in the same cycle at 00:01 → FLASH with done; startStop ignored;
  - startStop in READY at 00:00 → stays in READY.

Source files
------------

// File: rtl/countdown_timer_ctrl.sv
// countdown_timer_ctrl: mm:ss BCD countdown timer with preset reload, pause/resume,
// auto-repeat, synchronous clear and a flashing LED bank on expiry.
module countdown_timer_ctrl #(
  parameter int unsigned TICK_DIV  = 50000000,
  parameter int unsigned FLASH_DIV = 25000000,
  parameter int unsigned LED_W     = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             set,
  input  logic             startStop,
  input  logic             repeat_en,
  input  logic [7:0]       sw,
  output logic [7:0]       min_bcd,
  output logic [7:0]       sec_bcd,
  output logic [LED_W-1:0] ledr,
  output logic [2:0]       state_o,
  output logic             running,
  output logic             done
);

  localparam int unsigned TickW  = $clog2(TICK_DIV);
  localparam int unsigned FlashW = $clog2(FLASH_DIV);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StSetSec = 3'd1,
    StSetMin = 3'd2,
    StReady  = 3'd3,
    StRun    = 3'd4,
    StFlash  = 3'd5
  } state_e;

  state_e             r_state, w_state_d;
  logic [7:0]         r_min, w_min_d;
  logic [7:0]         r_sec, w_sec_d;
  logic [15:0]        r_preset, w_preset_d;
  logic [TickW-1:0]   r_presc, w_presc_d;
  logic [FlashW-1:0]  r_flash_cnt, w_flash_cnt_d;
  logic [LED_W-1:0]   r_ledr, w_ledr_d;
  logic               r_running;
  logic               r_done, w_done_d;

  logic [7:0]         w_sw_sec, w_sw_min;
  logic [7:0]         w_dec_sec, w_dec_min;
  logic               w_tick, w_expire;

  function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  // One-step BCD decrement of a digit pair; 00 wraps to {tens_wrap, 9}.
  function automatic logic [7:0] dec_pair(input logic [7:0] v, input logic [3:0] tens_wrap);
    if (v[3:0] != 4'd0) begin
      return {v[7:4], v[3:0] - 4'd1};
    end else if (v[7:4] != 4'd0) begin
      return {v[7:4] - 4'd1, 4'd9};
    end
    return {tens_wrap, 4'd9};
  endfunction

  assign w_sw_sec  = {clamp(sw[7:4], 4'd5), clamp(sw[3:0], 4'd9)};
  assign w_sw_min  = {clamp(sw[7:4], 4'd9), clamp(sw[3:0], 4'd9)};
  assign w_tick    = (r_state == StRun) && (r_presc == TickW'(TICK_DIV - 1));
  assign w_dec_sec = dec_pair(r_sec, 4'd5);
  // Minutes borrow only when seconds roll over from 00.
  assign w_dec_min = (r_sec == 8'h00) ? dec_pair(r_min, 4'd9) : r_min;
  assign w_expire  = w_tick && (w_dec_sec == 8'h00) && (w_dec_min == 8'h00);

  // Next-state and datapath: clr, then expiry, then startStop, then set.
  always_comb begin
    w_state_d     = r_state;
    w_min_d       = r_min;
    w_sec_d       = r_sec;
    w_preset_d    = r_preset;
    w_presc_d     = r_presc;
    w_flash_cnt_d = r_flash_cnt;
    w_ledr_d      = '0;
    w_done_d      = 1'b0;
    if (clr) begin
      w_state_d     = StIdle;
      w_min_d       = '0;
      w_sec_d       = '0;
      w_preset_d    = '0;
      w_presc_d     = '0;
      w_flash_cnt_d = '0;
    end else begin
      case (r_state)
        StIdle: w_state_d = StSetSec;
        StSetSec: begin
          w_sec_d = w_sw_sec;
          if (set) w_state_d = StSetMin;
        end
        StSetMin: begin
          w_min_d = w_sw_min;
          if (set) begin
            w_state_d  = StReady;
            w_preset_d = {w_sw_min, r_sec};
            w_presc_d  = '0;
          end
        end
        StReady: begin
          if (startStop) begin
            if ({r_min, r_sec} != 16'h0000) w_state_d = StRun;
          end else if (set) begin
            w_state_d = StSetSec;
          end
        end
        StRun: begin
          if (w_tick) begin
            w_presc_d = '0;
            w_min_d   = w_dec_min;
            w_sec_d   = w_dec_sec;
          end else begin
            w_presc_d = r_presc + TickW'(1);
          end
          if (w_expire) begin
            w_done_d = 1'b1;
            if (repeat_en) begin
              w_min_d = r_preset[15:8];
              w_sec_d = r_preset[7:0];
            end else begin
              w_state_d     = StFlash;
              w_ledr_d      = {LED_W{1'b1}};
              w_flash_cnt_d = '0;
            end
          end else if (startStop) begin
            // Pause keeps the prescaler so resume continues the fractional second.
            w_state_d = StReady;
          end
        end
        StFlash: begin
          if (startStop) begin
            w_state_d     = StReady;
            w_min_d       = r_preset[15:8];
            w_sec_d       = r_preset[7:0];
            w_presc_d     = '0;
            w_flash_cnt_d = '0;
          end else if (r_flash_cnt == FlashW'(FLASH_DIV - 1)) begin
            w_flash_cnt_d = '0;
            w_ledr_d      = ~r_ledr;
          end else begin
            w_flash_cnt_d = r_flash_cnt + FlashW'(1);
            w_ledr_d      = r_ledr;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_min       <= '0;
      r_sec       <= '0;
      r_preset    <= '0;
      r_presc     <= '0;
      r_flash_cnt <= '0;
      r_ledr      <= '0;
      r_running   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_min       <= w_min_d;
      r_sec       <= w_sec_d;
      r_preset    <= w_preset_d;
      r_presc     <= w_presc_d;
      r_flash_cnt <= w_flash_cnt_d;
      r_ledr      <= w_ledr_d;
      r_running   <= (w_state_d == StRun);
      r_done      <= w_done_d;
    end
  end

  assign min_bcd = r_min;
  assign sec_bcd = r_sec;
  assign ledr    = r_ledr;
  assign state_o = r_state;
  assign running = r_running;
  assign done    = r_done;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Self-checking bench for countdown_timer_ctrl: directed scenarios plus random pulses,
// compared against an integer-seconds reference model.
module tb_countdown_timer_ctrl;

  localparam int unsigned TICK  = 4;
  localparam int unsigned FLASH = 3;
  localparam int unsigned LW    = 10;
  localparam int          ONES  = (1 << LW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clr = 1'b0;
  logic          set = 1'b0;
  logic          startStop = 1'b0;
  logic          repeat_en = 1'b0;
  logic [7:0]    sw = 8'h00;
  logic [7:0]    min_bcd, sec_bcd;
  logic [LW-1:0] ledr;
  logic [2:0]    state_o;
  logic          running, done;

  countdown_timer_ctrl #(
    .TICK_DIV  (TICK),
    .FLASH_DIV (FLASH),
    .LED_W     (LW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .set       (set),
    .startStop (startStop),
    .repeat_en (repeat_en),
    .sw        (sw),
    .min_bcd   (min_bcd),
    .sec_bcd   (sec_bcd),
    .ledr      (ledr),
    .state_o   (state_o),
    .running   (running),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: time kept as plain integer minutes/seconds.
  int m_st, m_min, m_sec, m_preset, m_phase, m_fph;
  bit m_led, m_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t, o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  function automatic int lim(input logic [3:0] d, input int mx);
    return (int'(d) > mx) ? mx : int'(d);
  endfunction

  task automatic model_reset();
    m_st = 0; m_min = 0; m_sec = 0; m_preset = 0; m_phase = 0; m_fph = 0;
    m_led = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_step(input bit c, input bit s, input bit ss, input bit rep,
                            input logic [7:0] v);
    int t;
    m_done = 1'b0;
    if (c) begin
      model_reset();
    end else begin
      case (m_st)
        0: m_st = 1;
        1: begin
          m_sec = lim(v[7:4], 5) * 10 + lim(v[3:0], 9);
          if (s) m_st = 2;
        end
        2: begin
          m_min = lim(v[7:4], 9) * 10 + lim(v[3:0], 9);
          if (s) begin m_st = 3; m_preset = m_min * 60 + m_sec; m_phase = 0; end
        end
        3: begin
          if (ss) begin
            if (m_min * 60 + m_sec != 0) m_st = 4;
          end else if (s) m_st = 1;
        end
        4: begin
          if (m_phase == int'(TICK) - 1) begin
            m_phase = 0;
            t = m_min * 60 + m_sec - 1;
            if (t == 0) begin
              m_done = 1'b1;
              if (rep) t = m_preset;
              else begin m_st = 5; m_led = 1'b1; m_fph = 0; end
            end else if (ss) m_st = 3;
            m_min = t / 60;
            m_sec = t % 60;
          end else begin
            m_phase++;
            if (ss) m_st = 3;
          end
        end
        default: begin
          if (ss) begin
            m_st = 3; m_min = m_preset / 60; m_sec = m_preset % 60;
            m_phase = 0; m_led = 1'b0; m_fph = 0;
          end else if (m_fph == int'(FLASH) - 1) begin
            m_fph = 0; m_led = ~m_led;
          end else m_fph++;
        end
      endcase
    end
    if (m_st != 5) m_led = 1'b0;
  endtask

  task automatic check_all();
    chk("state", 32'(state_o), 32'(m_st));
    chk("min", 32'(min_bcd), 32'(to_bcd(m_min)));
    chk("sec", 32'(sec_bcd), 32'(to_bcd(m_sec)));
    chk("ledr", 32'(ledr), (m_led ? 32'(ONES) : 32'd0));
    chk("running", 32'(running), 32'(m_st == 4));
    chk("done", 32'(done), 32'(m_done));
  endtask

  task automatic step(input bit c, input bit s, input bit ss, input logic [7:0] v);
    clr = c; set = s; startStop = ss; sw = v;
    model_step(c, s, ss, repeat_en, v);
    @(posedge clk);
    #1;
    clr = 1'b0; set = 1'b0; startStop = 1'b0;
    check_all();
  endtask

  task automatic program_time(input logic [7:0] mm, input logic [7:0] ssv);
    step(1'b1, 1'b0, 1'b0, ssv);
    step(1'b0, 1'b0, 1'b0, ssv);
    step(1'b0, 1'b0, 1'b0, ssv);
    step(1'b0, 1'b1, 1'b0, ssv);
    step(1'b0, 1'b0, 1'b0, mm);
    step(1'b0, 1'b1, 1'b0, mm);
  endtask

  initial begin
    int dn;
    bit rc, rs, rss;
    logic [7:0] rv;
    model_reset();
    #1;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_time", 32'({min_bcd, sec_bcd}), 32'd0);
    chk("rst_out", 32'({ledr, running, done}), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("idle_after_rel", 32'(state_o), 32'd0);

    // Reset release and switch validation.
    step(1'b0, 1'b0, 1'b0, 8'h7C);
    chk("setsec_entry", 32'(state_o), 32'd1);
    step(1'b0, 1'b0, 1'b0, 8'h7C);
    chk("sec_valid", 32'(sec_bcd), 32'h59);
    step(1'b0, 1'b1, 1'b0, 8'h7C);
    step(1'b0, 1'b0, 1'b0, 8'hA3);
    step(1'b0, 1'b1, 1'b0, 8'hA3);
    chk("min_valid", 32'(min_bcd), 32'h93);
    chk("ready", 32'(state_o), 32'd3);

    // Borrow chain from 01:00 to expiry.
    program_time(8'h01, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    dn = 0;
    for (int i = 1; i <= 240; i++) begin
      step(1'b0, 1'b0, 1'b0, 8'h00);
      if (i == 4) chk("borrow", 32'({min_bcd, sec_bcd}), 32'h0059);
      if (done) dn++;
    end
    chk("expire_done", 32'(done), 32'd1);
    chk("done_count", 32'(dn), 32'd1);
    chk("expire_flash", 32'(state_o), 32'd5);

    // Flash pattern and restart.
    chk("flash_entry", 32'(ledr), 32'(ONES));
    for (int k = 1; k < 12; k++) begin
      step(1'b0, 1'b0, 1'b0, 8'h00);
      chk("flash_pat", 32'(ledr), (((k / 3) % 2) == 0) ? 32'(ONES) : 32'd0);
    end
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("restart_state", 32'(state_o), 32'd3);
    chk("restart_time", 32'({min_bcd, sec_bcd}), 32'h0100);
    chk("restart_ledr", 32'(ledr), 32'd0);

    // Pause and resume keep the fractional second.
    program_time(8'h00, 8'h05);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("paused", 32'(state_o), 32'd3);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b0, 8'h00);
      chk("frozen", 32'({min_bcd, sec_bcd}), 32'h0004);
    end
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("resume_hold", 32'(sec_bcd), 32'h04);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("resume_dec", 32'(sec_bcd), 32'h03);

    // Repeat mode.
    program_time(8'h00, 8'h02);
    repeat_en = 1'b1;
    step(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 1; i <= 24; i++) begin
      step(1'b0, 1'b0, 1'b0, 8'h00);
      chk("rep_done", 32'(done), 32'((i % 8) == 0));
      chk("rep_running", 32'(running), 32'd1);
      if ((i % 8) == 0) chk("rep_reload", 32'({min_bcd, sec_bcd}), 32'h0002);
    end
    repeat_en = 1'b0;

    // Priority cases.
    program_time(8'h00, 8'h05);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b1, 8'h00);
    chk("clr_wins", 32'(state_o), 32'd0);
    program_time(8'h00, 8'h01);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("exp_over_ss", 32'(state_o), 32'd5);
    chk("exp_over_ss_done", 32'(done), 32'd1);
    program_time(8'h00, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("zero_start", 32'(state_o), 32'd3);

    // Asynchronous reset mid-RUN.
    program_time(8'h00, 8'h09);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    reset = 1'b0;
    #1;
    chk("arst_state", 32'(state_o), 32'd0);
    chk("arst_time", 32'({min_bcd, sec_bcd}), 32'd0);
    chk("arst_out", 32'({ledr, running, done}), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    check_all();

    // Random pulses with small time values so expiries happen often.
    for (int i = 0; i < 3000; i++) begin
      rc  = ($urandom_range(0, 63) == 0);
      rs  = ($urandom_range(0, 7) == 0);
      rss = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) rv = 8'($urandom);
      else rv = {4'h0, 4'($urandom_range(0, 3))};
      if ($urandom_range(0, 199) == 0) repeat_en = ~repeat_en;
      step(rc, rs, rss, rv);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
